// File: rtl/uart_tx_frame_controller_pkg.sv
// Shared UART definitions: frame state encodings, bit indices,
// parity mode and enable constants used by TX, RX and parity blocks.
package uart_tx_frame_controller_pkg;

  typedef enum logic [4:0] {
    INTERVAL  = 5'b00001,
    STARTBIT  = 5'b00010,
    DATABITS  = 5'b00100,
    PARITYBIT = 5'b01000,
    STOPBIT   = 5'b10000
  } tx_state_e;

  localparam logic [3:0] BIT0 = 4'd0;
  localparam logic [3:0] BIT1 = 4'd1;
  localparam logic [3:0] BIT2 = 4'd2;
  localparam logic [3:0] BIT3 = 4'd3;
  localparam logic [3:0] BIT4 = 4'd4;
  localparam logic [3:0] BIT5 = 4'd5;
  localparam logic [3:0] BIT6 = 4'd6;
  localparam logic [3:0] BIT7 = 4'd7;

  localparam logic EVEN    = 1'b0;
  localparam logic ODD     = 1'b1;
  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

endpackage

// File: rtl/uart_tx_frame_controller_if.sv
// Byte handshake between the TX FIFO and the frame controller.
interface uart_tx_frame_controller_if;

  logic       TxValid_i;
  logic [7:0] TxData_i;
  logic       TxReady_o;

  modport master (
    output TxValid_i,
    output TxData_i,
    input  TxReady_o
  );

  modport slave (
    input  TxValid_i,
    input  TxData_i,
    output TxReady_o
  );

endinterface

// File: rtl/uart_tx_frame_controller.sv
// UART transmit frame sequencer: one-byte holding register, one-hot
// frame FSM paced by the baud pulse, and a registered TxD line.
module uart_tx_frame_controller
  import uart_tx_frame_controller_pkg::*;
#(
  parameter int STOP_BITS = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       p_BaudSig_i,
  uart_tx_frame_controller_if.slave  tx,
  input  logic                       ParityEnable_i,
  input  logic                       ParityResult_i,
  output logic [4:0]                 State_o,
  output logic [3:0]                 BitCounter_o,
  output logic [7:0]                 Data_o,
  output logic                       TxD_o,
  output logic                       Busy_o
);

  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

  tx_state_e  state_q;
  logic [3:0] cnt_q;
  logic [7:0] data_q;
  logic [7:0] hold_q;
  logic       full_q;
  logic       par_en_q;
  logic       txd_q;
  logic       accept;
  logic [2:0] nxt_idx;

  assign accept       = tx.TxValid_i & ~full_q;
  assign tx.TxReady_o = ~full_q;
  assign nxt_idx      = cnt_q[2:0] + 3'd1;

  assign State_o      = state_q;
  assign BitCounter_o = cnt_q;
  assign Data_o       = data_q;
  assign TxD_o        = txd_q;
  assign Busy_o       = (state_q != INTERVAL);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= INTERVAL;
      cnt_q    <= BIT0;
      data_q   <= '0;
      hold_q   <= '0;
      full_q   <= 1'b0;
      par_en_q <= 1'b0;
      txd_q    <= 1'b1;
    end else begin
      if (accept) begin
        hold_q <= tx.TxData_i;
        full_q <= 1'b1;
      end
      // accept needs !full and a frame start needs full, so they never collide
      case (state_q)
        INTERVAL: begin
          if (p_BaudSig_i && full_q) begin
            data_q   <= hold_q;
            full_q   <= 1'b0;
            par_en_q <= ParityEnable_i;
            state_q  <= STARTBIT;
            txd_q    <= 1'b0;
          end
        end
        STARTBIT: begin
          if (p_BaudSig_i) begin
            state_q <= DATABITS;
            cnt_q   <= BIT0;
            txd_q   <= data_q[0];
          end
        end
        DATABITS: begin
          if (p_BaudSig_i) begin
            if (cnt_q == BIT7) begin
              cnt_q <= BIT0;
              if (par_en_q) begin
                state_q <= PARITYBIT;
                txd_q   <= ParityResult_i;
              end else begin
                state_q <= STOPBIT;
                txd_q   <= 1'b1;
              end
            end else begin
              cnt_q <= cnt_q + 4'd1;
              txd_q <= data_q[nxt_idx];
            end
          end
        end
        PARITYBIT: begin
          if (p_BaudSig_i) begin
            state_q <= STOPBIT;
            cnt_q   <= BIT0;
            txd_q   <= 1'b1;
          end
        end
        STOPBIT: begin
          if (p_BaudSig_i) begin
            txd_q <= 1'b1;
            if (cnt_q == LAST_STOP) begin
              state_q <= INTERVAL;
              cnt_q   <= BIT0;
            end else begin
              cnt_q <= cnt_q + 4'd1;
            end
          end
        end
        default: begin
          state_q <= INTERVAL;
          cnt_q   <= BIT0;
          txd_q   <= 1'b1;
        end
      endcase
    end
  end

endmodule
